vertex_fetch: RTL and testbench

Upstream feeder for the transformation stage. On a start pulse, walks a vertex memory from address 0 to `vertex_count_in-1` and presents each 4-component IEEE-754 single-precision position on a valid/ready stream. The stream is tagged with `obj_done_out` on the last vertex of the object. Sits between the scene BRAM and the transformation stage: `pos_out`, `valid_out` and `obj_done_out` drive its `pos`, `valid_in` and `obj_done_in`, and its `ready_out` drives `ready_in`.

---
 rtl/vertex_fetch.sv | 121 ++++++++++++
 tb/tb_vertex_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vertex_fetch.sv
// vertex_fetch: walks vertex memory 0..count-1 and streams {w,z,y,x} positions; VERTEX_FETCH_PREFETCH_EN enables credit-based pipelined reads
module vertex_fetch #(
  parameter int ADDR_WIDTH = 10,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH:0]   vertex_count_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [127:0]          mem_data_in,
  output logic [3:0][31:0]      pos_out,
  output logic                  valid_out,
  output logic                  obj_done_out,
  input  logic                  ready_in,
  output logic                  busy_out,
  output logic                  frame_done_out
);
  localparam int L = BRAM_LATENCY;
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH:0] count, n_issue, n_cap;
  logic issue_q, xfer, cap, last_cap, go, fetch_issue, issue;
  logic [L-1:0] trk;
  assign xfer = valid_out && ready_in;
  assign cap = trk[L-1];
  assign last_cap = n_cap == count - 1'b1;
  assign go = state == IDLE && start_in;
  assign issue = (go && vertex_count_in != '0) || fetch_issue;
`ifdef VERTEX_FETCH_PREFETCH_EN
  // Credits cover the address stage, the L tracker stages and the presented head,
  // so a full pipeline plus the head keeps one vertex per cycle flowing.
  localparam int D = L + 2;
  localparam int CW = $clog2(D + 1);
  localparam int PW = $clog2(D);
  logic [128:0] fifo [D];
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] used, pend;
  assign fetch_issue = state == FETCH && n_issue != count && int'(pend) - int'(xfer) < D;
  assign valid_out = used != '0;
  assign {obj_done_out, pos_out} = fifo[rd];
  // buffer returning vertices and count outstanding credits
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < D; i++) fifo[i] <= '0;
      rd <= '0;
      wr <= '0;
      used <= '0;
      pend <= '0;
    end else begin
      if (cap) begin
        fifo[wr] <= {last_cap, mem_data_in};
        wr <= wr == PW'(D - 1) ? '0 : wr + 1'b1;
      end
      if (xfer) rd <= rd == PW'(D - 1) ? '0 : rd + 1'b1;
      used <= used + CW'(cap) - CW'(xfer);
      pend <= pend + CW'(issue) - CW'(xfer);
    end
  end
`else
  assign fetch_issue = state == FETCH && xfer && n_issue != count;
  // capture returning data into the output register; valid drops only on a transfer
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pos_out <= '0;
      valid_out <= 1'b0;
      obj_done_out <= 1'b0;
    end else if (cap) begin
      pos_out <= mem_data_in;
      valid_out <= 1'b1;
      obj_done_out <= last_cap;
    end else if (xfer) begin
      valid_out <= 1'b0;
      obj_done_out <= 1'b0;
    end
  end
`endif
  // control FSM, read address issue and read-latency tracker
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      count <= '0;
      n_issue <= '0;
      n_cap <= '0;
      issue_q <= 1'b0;
      trk <= '0;
      mem_addr_out <= '0;
      busy_out <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      issue_q <= issue;
      trk <= L'({trk, issue_q});
      if (fetch_issue) begin
        mem_addr_out <= n_issue[ADDR_WIDTH-1:0];
        n_issue <= n_issue + 1'b1;
      end
      if (cap) n_cap <= n_cap + 1'b1;
      case (state)
        IDLE: if (start_in) begin
          count <= vertex_count_in;
          n_issue <= {{ADDR_WIDTH{1'b0}}, 1'b1};
          n_cap <= '0;
          mem_addr_out <= '0;
          busy_out <= 1'b1;
          state <= vertex_count_in == '0 ? DONE : FETCH;
        end
        FETCH: if (xfer && obj_done_out) begin
          busy_out <= 1'b0;
          frame_done_out <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy_out <= 1'b0;
          frame_done_out <= !frame_done_out;
          state <= frame_done_out ? IDLE : DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vertex_fetch.sv
// tb_vertex_fetch: randomized and directed checks of vertex_fetch against a transfer-level reference
module tb_vertex_fetch;
  localparam int AW = 4;
  localparam int LAT = 2;
`ifdef VERTEX_FETCH_PREFETCH_EN
  localparam int PERIOD = 1;
`else
  localparam int PERIOD = LAT + 2;
`endif
  logic clk_in = 1'b0, rst_in = 1'b1, start_in = 1'b0, ready_in = 1'b0;
  logic [AW:0] vertex_count_in = '0;
  logic [AW-1:0] mem_addr_out;
  logic [127:0] mem_data_in;
  logic [3:0][31:0] pos_out;
  logic valid_out, obj_done_out, busy_out, frame_done_out;
  int checks = 0, errors = 0, cyc = 0, fd_cnt = 0, fd_cyc = 0;
  logic [127:0] pq[$];
  bit dq[$];
  int tq[$];
  logic [127:0] pipe [LAT];
  logic [127:0] last_pos;
  logic last_done;
  bit stalled = 0;

  vertex_fetch #(.ADDR_WIDTH(AW), .BRAM_LATENCY(LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .vertex_count_in(vertex_count_in),
    .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in), .pos_out(pos_out),
    .valid_out(valid_out), .obj_done_out(obj_done_out), .ready_in(ready_in),
    .busy_out(busy_out), .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [31:0] f2b(int v);
    int e = 0;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    while ((v >> (e + 1)) != 0) e++;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  function automatic logic [127:0] rec(int a);
    return {f2b(a + 3), f2b(a + 2), f2b(a + 1), f2b(a)};
  endfunction

  always @(posedge clk_in) begin
    pipe[0] <= rec(int'(mem_addr_out));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data_in = pipe[LAT-1];

  always @(negedge clk_in) begin
    if (stalled) begin
      checks++;
      assert (valid_out === 1'b1 && pos_out === last_pos && obj_done_out === last_done) else begin
        errors++;
        $error("FAIL stall_hold got valid=%b pos=%h done=%b exp valid=1 pos=%h done=%b",
               valid_out, pos_out, obj_done_out, last_pos, last_done);
      end
    end
    stalled = valid_out === 1'b1 && ready_in === 1'b0;
    last_pos = pos_out;
    last_done = obj_done_out;
    if (valid_out === 1'b1 && ready_in === 1'b1) begin
      pq.push_back(pos_out);
      dq.push_back(obj_done_out);
      tq.push_back(cyc);
    end
    if (frame_done_out === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // mode 0: ready held high, 1: random backpressure, 2: extra starts while busy and on frame_done
  task automatic walk(int n, int mode, output int k);
    int budget = 0;
    int hold = 0;
    pq.delete();
    dq.delete();
    tq.delete();
    fd_cnt = 0;
    vertex_count_in = (AW + 1)'(n);
    ready_in = mode != 1;
    start_in = 1'b1;
    tick();
    k = cyc;
    start_in = 1'b0;
    chk("start_busy", busy_out, 1);
    chk("start_addr", mem_addr_out, 0);
    while (frame_done_out !== 1'b1 && budget < 400) begin
      if (mode == 1) begin
        if (hold > 0) hold--;
        else begin
          ready_in = 1'($urandom_range(0, 1));
          if (!ready_in) hold = $urandom_range(0, 6);
        end
      end
      start_in = mode == 2 && budget == 3;
      tick();
      start_in = 1'b0;
      budget++;
    end
    chk("walk_timeout", budget < 400, 1);
    chk("busy_fall", busy_out, 0);
    if (mode == 2) begin
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      chk("start_on_done_dropped", busy_out, 0);
    end
    ready_in = 1'b1;
    repeat (4) tick();
    chk("n_xfers", pq.size(), n);
    for (int i = 0; i < pq.size() && i < n; i++) begin
      chk($sformatf("pos[%0d]", i), pq[i], rec(i));
      chk($sformatf("obj_done[%0d]", i), dq[i], i == n - 1);
    end
    chk("frame_pulses", fd_cnt, 1);
    if (pq.size() > 0) chk("frame_timing", fd_cyc, tq[pq.size()-1] + 1);
    else chk("zero_frame_timing", fd_cyc, k + 1);
  endtask

  initial begin
    int k;
    int b;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_done", obj_done_out, 0);
    chk("rst_pos", pos_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_frame", frame_done_out, 0);
    rst_in = 1'b0;
    tick();
    walk(4, 0, k);
    chk("first_valid", tq[0], k + LAT + 1);
    walk(3, 1, k);
    walk(7, 1, k);
    walk(6, 2, k);
    walk(0, 0, k);
    chk("zero_addr", mem_addr_out, 0);
    walk(16, 0, k);
    chk("full_first_valid", tq[0], k + LAT + 1);
    for (int i = 1; i < tq.size(); i++) chk($sformatf("period[%0d]", i), tq[i] - tq[i-1], PERIOD);
    chk("addr_max_no_wrap", mem_addr_out, 15);
    pq.delete();
    vertex_count_in = 5;
    ready_in = 1'b1;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    b = 0;
    while (pq.size() < 2 && b < 100) begin
      @(negedge clk_in);
      #1;
      b++;
    end
    chk("rst_wait", b < 100, 1);
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_done", obj_done_out, 0);
    chk("mid_rst_pos", pos_out, 0);
    chk("mid_rst_addr", mem_addr_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_frame", frame_done_out, 0);
    tick();
    rst_in = 1'b0;
    tick();
    walk(3, 0, k);
    chk("post_rst_first_valid", tq[0], k + LAT + 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
